// File: rtl/mul6_seq_pkg.sv
// mul6_seq_pkg: shared widths and FSM encoding for the 6x6 sequential multiplier
package mul6_seq_pkg;
  localparam int DATA_W = 6;
  localparam int PROD_W = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mul6_seq_if.sv
// mul6_seq_if: operand/product valid-ready handshake bundle
interface mul6_seq_if;
  import mul6_seq_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] a, b;
  logic [PROD_W-1:0] product;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, product);
endinterface

// File: rtl/mul6_seq_cla.sv
// CLA_6bit: 6-bit carry-lookahead adder, every carry expanded from generate/propagate terms
module CLA_6bit
  import mul6_seq_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] S,
  output logic              Cout
);
  logic [DATA_W-1:0] g, p;
  logic [DATA_W:1] c;
  assign g = A & B;
  assign p = A ^ B;
  for (genvar i = 0; i < DATA_W; i++) begin : g_c
    logic [i:0] t;
    for (genvar j = 0; j <= i; j++) begin : g_t
      if (j == i) begin : g_self
        assign t[j] = g[j];
      end else begin : g_prop
        assign t[j] = g[j] & (&p[i:j+1]);
      end
    end
    assign c[i+1] = |t;
  end
  assign S = p ^ {c[DATA_W-1:1], 1'b0};
  assign Cout = c[DATA_W];
endmodule

// File: rtl/mul6_seq.sv
// mul6_seq: iterative 6x6 shift-add multiplier with fixed 6-cycle latency
module mul6_seq
  import mul6_seq_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  mul6_seq_if.slave m
);
  state_t state;
  logic [DATA_W-1:0] hi, lo, mcand, s;
  logic [2:0] cnt;
  logic c;
  CLA_6bit u_cla (.A(hi), .B({DATA_W{lo[0]}} & mcand), .S(s), .Cout(c));
  assign m.in_ready = state == IDLE;
  assign m.out_valid = state == DONE;
  assign m.product = {hi, lo};
  // handshake FSM plus one shift-add step per RUN cycle; unused encoding falls back to IDLE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      mcand <= '0;
      cnt <= '0;
    end else
      case (state)
        IDLE: if (m.in_valid) begin
          mcand <= m.a;
          lo <= m.b;
          hi <= '0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          hi <= {c, s[DATA_W-1:1]};
          lo <= {s[0], lo[DATA_W-1:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd5) state <= DONE;
        end
        DONE: if (m.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mul6_seq.sv
// tb_mul6_seq: directed and exhaustive checks of the sequential multiplier
module tb_mul6_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  mul6_seq_if m ();
  mul6_seq dut (.clk(clk), .rst_n(rst_n), .m(m));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!m.out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 6);
  endtask
  task automatic run_op(input logic [5:0] x, input logic [5:0] y, input string tag);
    chk({tag, ".rdy"}, 32'(m.in_ready), 1);
    m.a = x;
    m.b = y;
    m.in_valid = 1'b1;
    m.out_ready = 1'b1;
    tick;
    m.in_valid = 1'b0;
    wait_out(tag);
    chk({tag, ".prod"}, 32'(m.product), 32'(x) * 32'(y));
    tick;
    chk({tag, ".idle"}, 32'(m.in_ready), 1);
    chk({tag, ".ovld"}, 32'(m.out_valid), 0);
  endtask
  initial begin
    m.in_valid = 1'b0;
    m.out_ready = 1'b0;
    m.a = '0;
    m.b = '0;
    tick;
    chk("rst.rdy", 32'(m.in_ready), 1);
    chk("rst.ovld", 32'(m.out_valid), 0);
    chk("rst.prod", 32'(m.product), 0);
    rst_n = 1'b1;
    run_op(6'd63, 6'd63, "max");
    chk("max.hold", 32'(m.product), 12'hF81);
    run_op(6'd0, 6'd45, "zero_a");
    run_op(6'd45, 6'd0, "zero_b");
    m.a = 6'd1;
    m.b = 6'd1;
    m.in_valid = 1'b1;
    m.out_ready = 1'b0;
    tick;
    m.a = 6'd7;
    m.b = 6'd9;
    wait_out("stall");
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("stall.rdy", 32'(m.in_ready), 0);
      chk("stall.ovld", 32'(m.out_valid), 1);
      chk("stall.prod", 32'(m.product), 1);
    end
    m.in_valid = 1'b0;
    m.out_ready = 1'b1;
    tick;
    chk("stall.idle", 32'(m.in_ready), 1);
    chk("stall.ovld0", 32'(m.out_valid), 0);
    chk("stall.keep", 32'(m.product), 1);
    m.a = 6'd37;
    m.b = 6'd22;
    m.in_valid = 1'b1;
    tick;
    m.a = 6'd50;
    m.b = 6'd3;
    wait_out("b2b1");
    chk("b2b1.prod", 32'(m.product), 814);
    tick;
    chk("b2b.gap_rdy", 32'(m.in_ready), 1);
    chk("b2b.gap_prod", 32'(m.product), 814);
    tick;
    chk("b2b2.acc", 32'(m.in_ready), 0);
    chk("b2b2.load", 32'(m.product), 3);
    m.in_valid = 1'b0;
    wait_out("b2b2");
    chk("b2b2.prod", 32'(m.product), 150);
    tick;
    chk("b2b2.idle", 32'(m.in_ready), 1);
    m.a = 6'd42;
    m.b = 6'd17;
    m.in_valid = 1'b1;
    tick;
    m.in_valid = 1'b0;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort.rdy", 32'(m.in_ready), 1);
    chk("abort.ovld", 32'(m.out_valid), 0);
    chk("abort.prod", 32'(m.product), 0);
    rst_n = 1'b1;
    run_op(6'd5, 6'd9, "after_rst");
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] idx;
      idx = 12'(i * 1237 + 91);
      run_op(idx[11:6], idx[5:0], "sweep");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul6_seq.md
MUL6_SEQ -- requirements
Module: mul6_seq

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 6 bits and the product width at 12 bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  6  unsigned multiplicand.
REQ-007 b  input  6  unsigned multiplier.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  12  unsigned a*b.

Function
REQ-011 The block SHALL implement an iterative shift-add multiplier with FSM states IDLE, RUN and DONE.
REQ-012 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE, both decoded directly from state.
REQ-013 Accept: on an edge with state IDLE and in_valid=1, the block SHALL register mcand<=a, set lo<=b, hi<=0 and cnt<=0, and go to RUN.
REQ-014 While IDLE and in_valid=0, the block SHALL hold all registers.
REQ-015 Each RUN cycle SHALL compute {c,s}=hi+mcand through the 6-bit adder when lo[0]=1, else {c,s}={0,hi}.
REQ-016 Each RUN cycle SHALL then update hi<={c,s[5:1]}, lo<={s[0],lo[5:1]} and cnt<=cnt+1.
REQ-017 RUN SHALL last exactly 6 cycles; on the edge where cnt=5 the state SHALL become DONE.
REQ-018 Latency: out_valid SHALL rise exactly 6 clocks after the accepting edge, independent of operand values; there is no early exit.
REQ-019 product SHALL equal {hi,lo}, shall be exact for all 4096 operand pairs, and no overflow is possible (63*63 = 3969 < 4096).
REQ-020 In DONE, product and out_valid SHALL be held stable until out_ready=1.
REQ-021 On an edge with DONE and out_ready=1, the state SHALL go to IDLE.
REQ-022 No new operands SHALL be accepted on the same edge as the DONE-to-IDLE transition; the next accept is possible one cycle later, giving a minimum initiation interval of 8 cycles.
REQ-023 After handoff, product SHALL keep its last value until the next RUN begins.
REQ-024 in_valid SHALL be ignored outside IDLE, and a/b SHALL be sampled only at the accepting edge.
REQ-025 out_ready SHALL be ignored outside DONE.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force state=IDLE, hi=0, lo=0, mcand=0 and cnt=0, giving in_ready=1, out_valid=0 and product=0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation and discard it; no stale out_valid pulse SHALL appear after reset release.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 The shared pipeline package SHALL hold the DATA_W=6 constant, the PROD_W=12 constant and the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
REQ-030 Encoding 2'd3 SHALL recover to IDLE.
REQ-031 The adder SHALL be a single CLA_6bit instance with A=hi, B=mcand gated by lo[0], and S/Cout feeding the shift logic; no other arithmetic sub-module SHALL be used.
REQ-032 cnt SHALL be 3 bits wide.

Verification
REQ-033 Scenario: a=63, b=63, out_ready=1 -> out_valid rises 6 clocks after the accept and product=12'hF81 (3969).
REQ-034 Scenario: a=0, b=45, then a=45, b=0 -> both products are 0 with the same 6-cycle latency.
REQ-035 Scenario: a=1, b=1, with out_ready held 0 for 10 cycles -> product=1 stays stable, in_ready=0 throughout, and the block returns to IDLE one edge after out_ready=1.
REQ-036 Scenario: back-to-back in_valid=1 with pairs (37,22) then (50,3), out_ready=1 -> products 814 then 150, the second accept lands 8 cycles after the first, and the second pair is not captured early.
REQ-037 Scenario: rst_n pulsed low at RUN cycle 3 of 42*17 -> immediately in_ready=1, out_valid=0 and product=0; a following 5*9 yields 45.
REQ-038 Scenario: random sweep of all 4096 pairs against a reference model -> zero mismatches and fixed 6-cycle latency.
